// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: req/ack data-memory access with lane
// steering, load extension, pipeline stall and fault/timeout reporting.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic [1:0]  ctrl_memSize_ex_mem,
    input  logic        ctrl_memSigned_ex_mem,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_data_into_mem,
    output logic        stall,
    output logic [31:0] read_data_from_mem,
    output logic        read_valid,
    output logic        access_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        fault_q, fault_d;

    logic        op;
    logic        bad;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [31:0] ld_ext;

    always_comb begin
        op   = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
        bad  = (ctrl_memRead_ex_mem & ctrl_memWrite_ex_mem)
             | (ctrl_memSize_ex_mem == 2'b11)
             | ((ctrl_memSize_ex_mem == 2'b01) & mem_address[0])
             | ((ctrl_memSize_ex_mem == 2'b10) & (|mem_address[1:0]));
        be_n = 4'b1111;
        wd_n = write_data_into_mem;
        unique case (ctrl_memSize_ex_mem)
            2'b00: begin
                be_n = 4'b0001 << mem_address[1:0];
                wd_n = {4{write_data_into_mem[7:0]}};
            end
            2'b01: begin
                be_n = mem_address[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{write_data_into_mem[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection uses the byte offset latched at request time.
    always_comb begin
        unique case (lo_q)
            2'd0:    lbyte = mem_rdata[7:0];
            2'd1:    lbyte = mem_rdata[15:8];
            2'd2:    lbyte = mem_rdata[23:16];
            default: lbyte = mem_rdata[31:24];
        endcase
        lhalf = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   ld_ext = {{24{sgn_q & lbyte[7]}}, lbyte};
            2'b01:   ld_ext = {{16{sgn_q & lhalf[15]}}, lhalf};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        stall    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op) begin
                    stall = 1'b1;
                    if (bad) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = ctrl_memWrite_ex_mem;
                        addr_d  = mem_address[31:2];
                        be_d    = be_n;
                        wdata_d = wd_n;
                        lo_d    = mem_address[1:0];
                        size_d  = ctrl_memSize_ex_mem;
                        sgn_d   = ctrl_memSigned_ex_mem;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d  = ld_ext;
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 30'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            lo_q     <= 2'd0;
            size_q   <= 2'd0;
            sgn_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
        end
    end

    assign read_data_from_mem = rdata_q;
    assign read_valid         = rvalid_q;
    assign access_fault       = fault_q;
    assign mem_req            = req_q;
    assign mem_we             = we_q;
    assign mem_addr           = addr_q;
    assign mem_be             = be_q;
    assign mem_wdata          = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4 and a hand-driven
// memory ack; expected values are hand-computed per vector.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr, sg;
    logic [1:0]  sz;
    logic [31:0] addr, wdat;
    logic        stall;
    logic [31:0] rdo;
    logic        read_valid, access_fault;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ctrl_memRead_ex_mem  (rd),
        .ctrl_memWrite_ex_mem (wr),
        .ctrl_memSize_ex_mem  (sz),
        .ctrl_memSigned_ex_mem(sg),
        .mem_address          (addr),
        .write_data_into_mem  (wdat),
        .stall                (stall),
        .read_data_from_mem   (rdo),
        .read_valid           (read_valid),
        .access_fault         (access_fault),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_be               (mem_be),
        .mem_wdata            (mem_wdata),
        .mem_rdata            (mem_rdata),
        .mem_ack              (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Observations of one transaction; cycle 0 is the cycle the op appears.
    int          t_done, t_stall, t_req;
    logic [3:0]  t_be;
    logic        t_we, t_vld, t_flt, t_after;
    logic [29:0] t_wa;
    logic [31:0] t_wd, t_rd;

    task automatic run(input logic r, input logic w, input logic [1:0] s,
                       input logic g, input logic [31:0] a,
                       input logic [31:0] d, input int ackc,
                       input logic [31:0] rdat);
        t_done = -1; t_stall = 0; t_req = 0;
        t_be = 0; t_we = 0; t_wa = 0; t_wd = 0;
        t_vld = 0; t_flt = 0; t_rd = 0; t_after = 1'b1;
        rd = r; wr = w; sz = s; sg = g; addr = a; wdat = d;
        for (int c = 0; c < 20 && t_done < 0; c++) begin
            mem_ack = (c == ackc);
            mem_rdata = rdat;
            #1;
            if (!stall) begin
                t_done = c;
                t_vld = read_valid;
                t_flt = access_fault;
                t_rd = rdo;
                if (mem_req) t_req += 100;
            end else begin
                t_stall++;
                if (mem_req) begin
                    t_req++;
                    t_be = mem_be; t_we = mem_we;
                    t_wa = mem_addr; t_wd = mem_wdata;
                end
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b0;
        rd = 0; wr = 0;
        @(posedge clk); #1;
        t_after = read_valid | access_fault | mem_req | stall;
    endtask

    initial begin
        reset = 1; rd = 0; wr = 0; sz = 0; sg = 0; addr = 0; wdat = 0;
        mem_ack = 0; mem_rdata = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rd", rdo, 0);
        chk("rst_flags", {30'd0, read_valid, access_fault}, 0);
        chk("rst_bus", {mem_be, 3'd0, mem_we, 24'd0}, 0);
        reset = 0;
        @(posedge clk); #1;

        run(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 3, 0);
        chk("sw_done", t_done, 4);
        chk("sw_stall", t_stall, 4);
        chk("sw_req", t_req, 3);
        chk("sw_addr", 32'(t_wa), 32'h4);
        chk("sw_be", 32'(t_be), 32'hF);
        chk("sw_wd", t_wd, 32'hDEADBEEF);
        chk("sw_we", 32'(t_we), 1);
        chk("sw_vld", {t_vld, t_flt}, 0);
        chk("sw_after", 32'(t_after), 0);

        run(0, 1, 2'b00, 0, 32'h7, 32'h000000A5, 1, 0);
        chk("sb_done", t_done, 2);
        chk("sb_be", 32'(t_be), 32'h8);
        chk("sb_wd", t_wd, 32'hA5A5A5A5);
        chk("sb_vld", {t_vld, t_flt}, 0);

        run(1, 0, 2'b00, 1, 32'h7, 0, 1, 32'hA5000000);
        chk("lb_done", t_done, 2);
        chk("lb_we", 32'(t_we), 0);
        chk("lb_be", 32'(t_be), 32'h8);
        chk("lb_data", t_rd, 32'hFFFFFFA5);
        chk("lb_vld", {t_vld, t_flt}, 2'b10);
        chk("lb_after", 32'(t_after), 0);
        chk("lb_hold", rdo, 32'hFFFFFFA5);

        run(1, 0, 2'b00, 0, 32'h7, 0, 1, 32'hA5000000);
        chk("lbu_data", t_rd, 32'h000000A5);

        run(1, 0, 2'b01, 1, 32'h2, 0, 2, 32'h80001234);
        chk("lh_be", 32'(t_be), 32'hC);
        chk("lh_data", t_rd, 32'hFFFF8000);
        chk("lh_done", t_done, 3);

        run(1, 0, 2'b01, 1, 32'h3, 0, 1, 32'h11111111);
        chk("lh3_done", t_done, 1);
        chk("lh3_stall", t_stall, 1);
        chk("lh3_req", t_req, 0);
        chk("lh3_flt", {t_vld, t_flt}, 2'b01);
        chk("lh3_after", 32'(t_after), 0);

        run(1, 0, 2'b10, 0, 32'h6, 0, 1, 32'h11111111);
        chk("lw6_done", t_done, 1);
        chk("lw6_req", t_req, 0);
        chk("lw6_flt", {t_vld, t_flt}, 2'b01);
        chk("lw6_rd", t_rd, 32'hFFFF8000);

        run(1, 0, 2'b10, 0, 32'h20, 0, -1, 32'h99999999);
        chk("to_req", t_req, 4);
        chk("to_done", t_done, 5);
        chk("to_flt", {t_vld, t_flt}, 2'b01);
        chk("to_rd", t_rd, 32'hFFFF8000);

        run(1, 0, 2'b10, 0, 32'h20, 0, 4, 32'h12345678);
        chk("ack4_done", t_done, 5);
        chk("ack4_flt", {t_vld, t_flt}, 2'b10);
        chk("ack4_rd", t_rd, 32'h12345678);

        run(1, 1, 2'b10, 0, 32'h0, 32'h1, 1, 0);
        chk("rw_flt", {t_vld, t_flt}, 2'b01);
        chk("rw_req", t_req, 0);

        run(1, 0, 2'b11, 0, 32'h0, 0, 1, 0);
        chk("sz3_flt", {t_vld, t_flt}, 2'b01);
        chk("sz3_req", t_req, 0);

        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("spur", {28'd0, read_valid, access_fault, mem_req, stall}, 0);
        chk("spur_rd", rdo, 32'h12345678);

        rd = 1; sz = 2'b10; sg = 0; addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rb_req", 32'(mem_req), 1);
        reset = 1; rd = 0;
        @(posedge clk); #1;
        reset = 0;
        chk("rb_req0", 32'(mem_req), 0);
        chk("rb_stall", 32'(stall), 0);
        chk("rb_rd", rdo, 0);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("rb_ign", {29'd0, read_valid, access_fault, mem_req}, 0);
        chk("rb_ign_rd", rdo, 0);

        run(1, 0, 2'b00, 0, 32'h1, 0, 2, 32'h0000C300);
        chk("post_done", t_done, 3);
        chk("post_be", 32'(t_be), 32'h2);
        chk("post_rd", t_rd, 32'h000000C3);
        chk("post_vld", {t_vld, t_flt}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
